serial_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares one double-buffered parallel-to-serial byte transmitter among `NUM_REQ` byte sources. Each requester presents a byte with a request/acknowledge handshake. The arbiter loads the winning byte into the transmitter with an active-low load strobe, follows the transmitter's `busy` flag through start and completion, inserts an inter-byte gap, then rotates priority. It sits on the load-side clock domain, between the byte producers and the serial transmitter.

---
 rtl/serial_tx_arbiter_if.sv | 27 ++
 rtl/serial_tx_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Request/transmitter bundle for serial_tx_arbiter. The master modport is the
// arbiter side; the slave modport is the requesters plus the serial transmitter.
interface serial_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [GID_W-1:0]     grant_id;
  logic                 active;
  logic                 sr_set_enable;
  logic [7:0]           sr_data;
  logic                 sr_busy;
  logic                 err;

  modport master (
    input  req, req_data, sr_busy,
    output ack, grant_id, active, sr_set_enable, sr_data, err
  );

  modport slave (
    output req, req_data, sr_busy,
    input  ack, grant_id, active, sr_set_enable, sr_data, err
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one double-buffered serial byte transmitter.
// Optional watchdog on the busy handshake: define SERIAL_TX_ARB_WATCHDOG_EN.
module serial_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 set_clk,
  input  logic                 reset,
  serial_tx_arbiter_if.master  bus
);
  localparam int unsigned GID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [GID_W-1:0]   ptr_q, ptr_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [GID_W-1:0]   ptr_next;
  logic [7:0]         data_q, data_d;
  logic               strobe_n_q, strobe_n_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [15:0]        gap_q, gap_d;
  logic [1:0]         sync_q;
  logic               busy_s;

  logic               win_found;
  logic [GID_W-1:0]   win_id;
  logic [7:0]         win_data;
  logic [GID_W:0]     scan_sum;
  logic [GID_W-1:0]   scan_idx;

`ifdef SERIAL_TX_ARB_WATCHDOG_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic        wd_expired;

  assign wd_expired = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  assign busy_s   = sync_q[1];
  assign ptr_next = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // First requester at or after the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr_q} + (GID_W+1)'(i);
      if (scan_sum >= (GID_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (GID_W+1)'(NUM_REQ);
      scan_idx = scan_sum[GID_W-1:0];
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
        win_data  = bus.req_data[{scan_idx, 3'b000} +: 8];
      end
    end
  end

  // Strobe and ack are registered on entry to LOAD so they are clean for exactly that cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    data_d     = data_q;
    strobe_n_d = 1'b1;
    ack_d      = '0;
    gap_d      = gap_q;
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
    wd_d       = wd_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d    = win_id;
          data_d     = win_data;
          strobe_n_d = 1'b0;
          ack_d      = NUM_REQ'(1) << win_id;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_START;
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      S_WAIT_START: begin
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
        wd_d = wd_q + 16'd1;
`endif
        if (busy_s) begin
          state_d = S_WAIT_DONE;
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
          wd_d    = '0;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_GAP;
          gap_d   = '0;
          ptr_d   = ptr_next;
`endif
        end
      end
      S_WAIT_DONE: begin
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
        wd_d = wd_q + 16'd1;
`endif
        if (!busy_s) begin
          state_d = S_GAP;
          gap_d   = '0;
          ptr_d   = ptr_next;
`ifdef SERIAL_TX_ARB_WATCHDOG_EN
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_GAP;
          gap_d   = '0;
          ptr_d   = ptr_next;
`endif
        end
      end
      S_GAP: begin
        // GAP always lasts at least one cycle, even with GAP_CYCLES = 0.
        if (32'(gap_q) + 32'd1 >= GAP_CYCLES)
          state_d = S_IDLE;
        else
          gap_d = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge set_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      strobe_n_q <= 1'b1;
      ack_q      <= '0;
      gap_q      <= '0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      strobe_n_q <= strobe_n_d;
      ack_q      <= ack_d;
      gap_q      <= gap_d;
      sync_q     <= {sync_q[0], bus.sr_busy};
    end
  end

`ifdef SERIAL_TX_ARB_WATCHDOG_EN
  always_ff @(posedge set_clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack           = ack_q;
  assign bus.grant_id      = grant_q;
  assign bus.active        = (state_q != S_IDLE);
  assign bus.sr_set_enable = strobe_n_q;
  assign bus.sr_data       = data_q;
endmodule
